// File: rtl/pipe_skid_reg.sv
// ============================================================================
// Module      : pipe_skid_reg
// Description : Two-entry pipeline skid register with flush, bubble control
//               zeroing and a saturating backpressure counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pipe_skid_reg #(
    parameter int DATA_W      = 101,
    parameter int CTRL_W      = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   FLUSH,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [CTRL_W-1:0]      IN_CTRL,
    input  logic [DATA_W-1:0]      IN_DATA,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [CTRL_W-1:0]      OUT_CTRL,
    output logic [DATA_W-1:0]      OUT_DATA,
    output logic [1:0]             OCC,
    output logic [STALL_CNT_W-1:0] STALL_CNT
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    localparam logic [STALL_CNT_W-1:0] c_stall_one = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]             r_state;
    logic [1:0]             w_next_state;
    logic [1:0]             r_occ;
    logic [1:0]             w_next_occ;
    logic [CTRL_W-1:0]      r_main_ctrl;
    logic [DATA_W-1:0]      r_main_data;
    logic [CTRL_W-1:0]      r_skid_ctrl;
    logic [DATA_W-1:0]      r_skid_data;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic w_accept;
    logic w_consume;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    assign w_accept  = IN_VALID & IN_READY & ~FLUSH;
    assign w_consume = OUT_VALID & OUT_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_EMPTY;
            r_occ   <= 2'd0;
        end else begin
            r_state <= w_next_state;
            r_occ   <= w_next_occ;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_next_state = S_ONE;
            S_ONE: begin
                if (w_accept && !w_consume)      w_next_state = S_TWO;
                else if (!w_accept && w_consume) w_next_state = S_EMPTY;
            end
            S_TWO:   if (w_consume) w_next_state = S_ONE;
            default: w_next_state = S_EMPTY;
        endcase
        if (FLUSH) w_next_state = S_EMPTY;

        case (w_next_state)
            S_ONE:   w_next_occ = 2'd1;
            S_TWO:   w_next_occ = 2'd2;
            default: w_next_occ = 2'd0;
        endcase
    end

    // Ready and valid come only from registered state, so no ready path crosses the block.
    always_comb begin
        IN_READY  = (r_state != S_TWO);
        OUT_VALID = (r_state == S_ONE) || (r_state == S_TWO);
        OUT_CTRL  = OUT_VALID ? r_main_ctrl : '0;
        OUT_DATA  = r_main_data;
        OCC       = r_occ;
        STALL_CNT = r_stall_cnt;
    end

    assign w_load_main_in   = w_accept & ((r_state == S_EMPTY) | ((r_state == S_ONE) & w_consume));
    assign w_load_skid      = w_accept & (r_state == S_ONE) & ~w_consume;
    assign w_load_main_skid = (r_state == S_TWO) & w_consume & ~FLUSH;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_ctrl <= IN_CTRL;
                r_main_data <= IN_DATA;
            end else if (w_load_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end else if (w_consume) begin
                r_main_ctrl <= '0;
            end
            if (w_load_skid) begin
                r_skid_ctrl <= IN_CTRL;
                r_skid_data <= IN_DATA;
            end
            // Squashed entries keep their payload but lose their control bits.
            if (FLUSH) begin
                r_main_ctrl <= '0;
                r_skid_ctrl <= '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (IN_VALID && !IN_READY && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + c_stall_one;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
// ============================================================================
// Module      : tb_pipe_skid_reg
// Description : Self-checking bench for pipe_skid_reg against a queue model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_skid_reg;

    localparam int DW = 101;
    localparam int CW = 4;
    localparam int SW = 16;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          CLK = 1'b0;
    logic          RST, FLUSH, IN_VALID, OUT_READY;
    logic [CW-1:0] IN_CTRL;
    logic [DW-1:0] IN_DATA;
    logic          IN_READY, OUT_VALID;
    logic [CW-1:0] OUT_CTRL;
    logic [DW-1:0] OUT_DATA;
    logic [1:0]    OCC;
    logic [SW-1:0] STALL_CNT;

    logic          s_in_ready, s_out_valid;
    logic [CW-1:0] s_out_ctrl;
    logic [DW-1:0] s_out_data;
    logic [1:0]    s_occ;
    logic [2:0]    s_stall_cnt;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 CLK = ~CLK;

    pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .STALL_CNT_W(SW)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_CTRL(IN_CTRL), .IN_DATA(IN_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_CTRL(OUT_CTRL), .OUT_DATA(OUT_DATA), .OCC(OCC), .STALL_CNT(STALL_CNT)
    );

    pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .STALL_CNT_W(3)) dut_small (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(s_in_ready),
        .IN_CTRL(IN_CTRL), .IN_DATA(IN_DATA), .OUT_VALID(s_out_valid), .OUT_READY(OUT_READY),
        .OUT_CTRL(s_out_ctrl), .OUT_DATA(s_out_data), .OCC(s_occ), .STALL_CNT(s_stall_cnt)
    );

    // Reference model: an in-order queue of at most two entries.
    ent_t          q[$];
    logic [DW-1:0] m_last  = '0;
    logic [SW-1:0] m_stall = '0;
    logic [2:0]    m_stall3 = '0;
    logic          m_ready;

    always @(posedge CLK) begin
        m_ready = (q.size() < 2);
        if (RST) begin
            q.delete();
            m_last   = '0;
            m_stall  = '0;
            m_stall3 = '0;
        end else begin
            if (IN_VALID && !m_ready) begin
                if (m_stall != '1) m_stall = m_stall + 1'b1;
                if (m_stall3 != 3'd7) m_stall3 = m_stall3 + 1'b1;
            end
            if (q.size() > 0 && OUT_READY) void'(q.pop_front());
            if (FLUSH) q.delete();
            else if (IN_VALID && m_ready) q.push_back({IN_CTRL, IN_DATA});
            if (q.size() > 0) m_last = q[0].d;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        RST = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        IN_CTRL = '0; IN_DATA = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (OUT_VALID !== 1'b0) begin n_errs++; $display("FAIL reset_valid got %0b exp 0", OUT_VALID); end
        n_checks++; if (OCC !== 2'd0) begin n_errs++; $display("FAIL reset_occ got %0d exp 0", OCC); end
        n_checks++; if (OUT_CTRL !== 4'h0) begin n_errs++; $display("FAIL reset_ctrl got %h exp 0", OUT_CTRL); end
        n_checks++; if (OUT_DATA !== '0) begin n_errs++; $display("FAIL reset_data got %h exp 0", OUT_DATA); end
        n_checks++; if (STALL_CNT !== '0) begin n_errs++; $display("FAIL reset_stall got %0d exp 0", STALL_CNT); end
        n_checks++; if (IN_READY !== 1'b1) begin n_errs++; $display("FAIL reset_ready got %0b exp 1", IN_READY); end
    endtask

    task automatic test_pass_through();
        logic [DW-1:0] vals [3];
        vals[0] = 'h11; vals[1] = 'h22; vals[2] = 'h33;
        do_reset();
        OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            IN_VALID = 1'b1; IN_DATA = vals[i]; IN_CTRL = 4'(i + 1);
            step();
            n_checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== vals[i]) begin
                n_errs++; $display("FAIL pass_data[%0d] got v=%0b %h exp v=1 %h", i, OUT_VALID, OUT_DATA, vals[i]); end
            n_checks++; if (OCC > 2'd1) begin n_errs++; $display("FAIL pass_occ[%0d] got %0d exp <=1", i, OCC); end
        end
        IN_VALID = 1'b0;
        step();
        n_checks++; if (OUT_VALID !== 1'b0 || OUT_CTRL !== 4'h0) begin
            n_errs++; $display("FAIL pass_drain got v=%0b c=%h exp v=0 c=0", OUT_VALID, OUT_CTRL); end
    endtask

    task automatic test_backpressure();
        do_reset();
        IN_VALID = 1'b1; IN_DATA = 'hA1; IN_CTRL = 4'h3;
        step();
        IN_DATA = 'hA2; IN_CTRL = 4'h5;
        step();
        n_checks++; if (OCC !== 2'd2 || IN_READY !== 1'b0) begin
            n_errs++; $display("FAIL bp_full got occ=%0d rdy=%0b exp occ=2 rdy=0", OCC, IN_READY); end
        IN_DATA = 'hEE;
        repeat (5) step();
        n_checks++; if (STALL_CNT !== 16'd5) begin n_errs++; $display("FAIL bp_stall got %0d exp 5", STALL_CNT); end
        n_checks++; if (OUT_DATA !== 'hA1 || OUT_CTRL !== 4'h3) begin
            n_errs++; $display("FAIL bp_head got %h/%h exp a1/3", OUT_DATA, OUT_CTRL); end
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        step();
        n_checks++; if (OUT_DATA !== 'hA2 || OUT_CTRL !== 4'h5 || IN_READY !== 1'b1 || OCC !== 2'd1) begin
            n_errs++; $display("FAIL bp_second got %h/%h rdy=%0b occ=%0d exp a2/5 rdy=1 occ=1",
                               OUT_DATA, OUT_CTRL, IN_READY, OCC); end
        step();
        n_checks++; if (OUT_VALID !== 1'b0 || OCC !== 2'd0) begin
            n_errs++; $display("FAIL bp_empty got v=%0b occ=%0d exp 0/0", OUT_VALID, OCC); end
    endtask

    task automatic test_flush();
        logic seen = 1'b0;
        do_reset();
        IN_VALID = 1'b1; IN_CTRL = 4'hF; IN_DATA = 'hB1;
        step();
        IN_DATA = 'hB2;
        step();
        IN_DATA = 'hCC; FLUSH = 1'b1;
        step();
        n_checks++; if (OCC !== 2'd0 || OUT_VALID !== 1'b0 || OUT_CTRL !== 4'h0) begin
            n_errs++; $display("FAIL flush_state got occ=%0d v=%0b c=%h exp 0/0/0", OCC, OUT_VALID, OUT_CTRL); end
        FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        repeat (3) begin
            step();
            if (OUT_VALID === 1'b1) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_errs++; $display("FAIL flush_drop got appear=%0b exp 0", seen); end
    endtask

    task automatic test_bubble();
        do_reset();
        IN_VALID = 1'b1; IN_CTRL = 4'b1111; IN_DATA = 'h5A;
        step();
        n_checks++; if (OUT_CTRL !== 4'b1111) begin n_errs++; $display("FAIL bubble_load got %b exp 1111", OUT_CTRL); end
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        step();
        n_checks++; if (OUT_VALID !== 1'b0 || OUT_CTRL !== 4'b0000) begin
            n_errs++; $display("FAIL bubble_ctrl got v=%0b c=%b exp 0/0000", OUT_VALID, OUT_CTRL); end
        n_checks++; if (OUT_DATA !== 'h5A) begin n_errs++; $display("FAIL bubble_hold got %h exp 5a", OUT_DATA); end
    endtask

    task automatic test_saturation();
        do_reset();
        IN_VALID = 1'b1; IN_DATA = 'h1;
        repeat (2) step();
        repeat (10) step();
        n_checks++; if (s_stall_cnt !== 3'd7) begin n_errs++; $display("FAIL sat_small got %0d exp 7", s_stall_cnt); end
        n_checks++; if (STALL_CNT !== 16'd10) begin n_errs++; $display("FAIL sat_wide got %0d exp 10", STALL_CNT); end
        repeat (2) step();
        n_checks++; if (s_stall_cnt !== 3'd7) begin n_errs++; $display("FAIL sat_hold got %0d exp 7", s_stall_cnt); end
        n_checks++; if (STALL_CNT !== 16'd12) begin n_errs++; $display("FAIL sat_wide2 got %0d exp 12", STALL_CNT); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        IN_VALID = 1'b1; IN_CTRL = 4'h9; IN_DATA = 'h77;
        repeat (4) step();
        RST = 1'b1; FLUSH = 1'b1;
        step();
        n_checks++; if (OUT_VALID !== 1'b0 || OCC !== 2'd0 || OUT_CTRL !== 4'h0 || OUT_DATA !== '0
                        || STALL_CNT !== '0 || IN_READY !== 1'b1) begin
            n_errs++; $display("FAIL midrst got v=%0b occ=%0d c=%h d=%h st=%0d rdy=%0b exp 0/0/0/0/0/1",
                               OUT_VALID, OCC, OUT_CTRL, OUT_DATA, STALL_CNT, IN_READY); end
        RST = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        step();
        n_checks++; if (OUT_VALID !== 1'b0) begin n_errs++; $display("FAIL midrst_pulse got %0b exp 0", OUT_VALID); end
    endtask

    task automatic test_soak();
        logic [DW-1:0] e_data;
        logic [CW-1:0] e_ctrl;
        do_reset();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            RST       = ($urandom_range(0, 511) == 0);
            FLUSH     = ($urandom_range(0, 31) == 0);
            IN_VALID  = $urandom_range(0, 3) != 0;
            OUT_READY = $urandom_range(0, 2) != 0;
            IN_CTRL   = CW'($urandom);
            IN_DATA   = DW'({$urandom, $urandom, $urandom, $urandom});
            step();
            e_data = (q.size() > 0) ? q[0].d : m_last;
            e_ctrl = (q.size() > 0) ? q[0].c : '0;
            n_checks++; if (OUT_VALID !== (q.size() > 0) || OCC !== 2'(q.size()) || IN_READY !== (q.size() < 2)) begin
                n_errs++; $display("FAIL soak_state cyc %0d got v=%0b occ=%0d rdy=%0b exp occ=%0d",
                                   cyc, OUT_VALID, OCC, IN_READY, q.size()); end
            n_checks++; if (OUT_DATA !== e_data || OUT_CTRL !== e_ctrl) begin
                n_errs++; $display("FAIL soak_payload cyc %0d got %h/%h exp %h/%h", cyc, OUT_CTRL, OUT_DATA, e_ctrl, e_data); end
            n_checks++; if (STALL_CNT !== m_stall || s_stall_cnt !== m_stall3) begin
                n_errs++; $display("FAIL soak_stall cyc %0d got %0d/%0d exp %0d/%0d",
                                   cyc, STALL_CNT, s_stall_cnt, m_stall, m_stall3); end
        end
    endtask

    initial begin
        idle_inputs();
        RST = 1'b1;
        test_reset();
        test_pass_through();
        test_backpressure();
        test_flush();
        test_bubble();
        test_saturation();
        test_reset_midstream();
        test_soak();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 101, meaning datapath payload width (ALU result 32 + write data 32 + Rd 5 + PC+4 32).
REQ-002 Parameter CTRL_W, default 4, meaning control payload width (RegWrite 1, ResultSrc 2, MemWrite 1); forced to zero whenever a bubble is presented.
REQ-003 Parameter STALL_CNT_W, default 16, meaning width of the saturating backpressure counter.
REQ-004 CLK  input  1  clock; all state updates on the rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 FLUSH  input  1  synchronous squash of all held entries.
REQ-007 IN_VALID  input  1  upstream entry present.
REQ-008 IN_READY  output  1  block can accept an entry this cycle.
REQ-009 IN_CTRL  input  CTRL_W  upstream control bits.
REQ-010 IN_DATA  input  DATA_W  upstream payload.
REQ-011 OUT_VALID  output  1  downstream entry present.
REQ-012 OUT_READY  input  1  downstream consumes the entry this cycle.
REQ-013 OUT_CTRL  output  CTRL_W  control bits of the presented entry.
REQ-014 OUT_DATA  output  DATA_W  payload of the presented entry.
REQ-015 OCC  output  2  number of held entries (0, 1 or 2).
REQ-016 STALL_CNT  output  STALL_CNT_W  count of cycles with IN_VALID=1 and IN_READY=0.

Function
REQ-017 Storage SHALL be a main register (drives the OUT_* ports) plus one skid register; states: EMPTY (OCC=0), ONE (main full), TWO (main and skid full).
REQ-018 accept = IN_VALID & IN_READY & !FLUSH; consume = OUT_VALID & OUT_READY.
REQ-019 IN_READY SHALL equal (state != TWO), decoded from registered state only, with no combinational path from OUT_READY.
REQ-020 EMPTY: accept -> ONE, main <= IN; otherwise stay.
REQ-021 ONE: accept & consume -> ONE, main <= IN; accept & !consume -> TWO, skid <= IN; !accept & consume -> EMPTY; otherwise hold.
REQ-022 TWO: consume -> ONE, main <= skid; otherwise hold; inputs ignored.
REQ-023 Latency SHALL be 1 cycle from accept in EMPTY to OUT_VALID=1; sustained throughput SHALL be 1 entry/cycle while OUT_READY=1.
REQ-024 Ordering SHALL be strict FIFO; no entry is dropped or duplicated except by FLUSH.
REQ-025 OUT_VALID SHALL be 1 in ONE and TWO and 0 in EMPTY; OUT_CTRL SHALL be all-zero whenever OUT_VALID=0; OUT_DATA holds its last value when empty.
REQ-026 FLUSH=1 SHALL force next state EMPTY and zero main and skid control bits; a same-cycle IN_VALID entry is dropped; a same-cycle consume still counts as delivered downstream.
REQ-027 STALL_CNT SHALL increment by 1 on each cycle with IN_VALID=1 and state=TWO, saturate at all-ones, and not be cleared by FLUSH.
REQ-028 OCC SHALL be registered and consistent with the state in the same cycle.

Reset
REQ-029 RST SHALL have priority over FLUSH and all handshakes.
REQ-030 While RST=1 at a rising edge: state <= EMPTY, OUT_VALID=0, OUT_CTRL=0, OUT_DATA=0, skid contents=0, OCC=0, STALL_CNT=0; IN_READY=1 from the first cycle after reset.
REQ-031 Reset asserted mid-operation (any state) SHALL discard held entries with no output pulse in the following cycle.

Verification
REQ-032 Pass-through: OUT_READY=1, IN_VALID=1 for 3 cycles with IN_DATA=0x11,0x22,0x33 -> OUT_DATA 0x11,0x22,0x33 on consecutive cycles, first one cycle after its accept; OCC stays at most 1.
REQ-033 Backpressure: OUT_READY=0, push 0xA1 then 0xA2 -> OCC=2, IN_READY=0; continued IN_VALID for 5 cycles -> STALL_CNT=5; OUT_READY=1 -> 0xA1 then 0xA2 delivered, IN_READY returns to 1 after the first consume.
REQ-034 Flush: state TWO, IN_VALID=1, FLUSH=1 -> next cycle OCC=0, OUT_VALID=0, OUT_CTRL=0; the dropped input never appears.
REQ-035 Bubble control: IN_CTRL=4'b1111 accepted, then OUT_READY=1 with IN_VALID=0 -> after consume, OUT_VALID=0 and OUT_CTRL=4'b0000.
REQ-036 Saturation: STALL_CNT_W=3, hold the stall condition 10 cycles -> STALL_CNT=7 and holds at 7.
REQ-037 Reset mid-stream: RST=1 in state TWO with FLUSH=1 -> all outputs at REQ-030 values next cycle; a random valid/ready/flush soak of 10k cycles matches a FIFO scoreboard.
